// File: rtl/mem_copy_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_copy_pkg: shared FSM state type and address-width helper for the      |
// | memory copy engine.                                                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_copy_engine.sv
// +--------------------------------------------------------------------------+
// | mem_copy_engine: copies a block of words through a combinational-read     |
// | memory, one read and one write per cycle. MEM_COPY_FILL_EN adds a fill    |
// | mode that writes a latched pattern instead of copying.                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter  int NUMWORDS  = 4096,
    parameter  int DATAWIDTH = 32,
    localparam int AW        = addr_width(NUMWORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AW-1:0]        src_i,
    input  logic [AW-1:0]        dst_i,
    input  logic [AW:0]          len_i,
`ifdef MEM_COPY_FILL_EN
    input  logic                 fill_i,
    input  logic [DATAWIDTH-1:0] pattern_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_re_o,
    output logic [AW-1:0]        mem_raddr_o,
    input  logic [DATAWIDTH-1:0] mem_rdata_i,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_waddr_o,
    output logic [DATAWIDTH-1:0] mem_wdata_o
);

    localparam logic [AW:0] c_max_len = (AW+1)'(NUMWORDS);

    state_e                 r_state;
    logic [AW-1:0]          r_src;
    logic [AW-1:0]          r_dst;
    logic [AW:0]            r_len;
    logic [AW:0]            r_rcnt;
    logic [AW-1:0]          r_wcnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_re;
    logic [AW-1:0]          r_raddr;
    logic                   r_we;
    logic [AW-1:0]          r_waddr;
    logic [DATAWIDTH-1:0]   r_wdata;

    logic [AW:0]            w_len_clamped;
    logic                   w_last_read;
    logic                   w_fill_req;
    logic                   w_fill;
    logic [DATAWIDTH-1:0]   w_wr_data;

`ifdef MEM_COPY_FILL_EN
    logic                   r_fill;
    logic [DATAWIDTH-1:0]   r_pattern;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fill    <= 1'b0;
            r_pattern <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_fill    <= fill_i;
            r_pattern <= pattern_i;
        end
    end

    assign w_fill_req = fill_i;
    assign w_fill     = r_fill;
    assign w_wr_data  = r_fill ? r_pattern : mem_rdata_i;
`else
    assign w_fill_req = 1'b0;
    assign w_fill     = 1'b0;
    assign w_wr_data  = mem_rdata_i;
`endif

    assign w_len_clamped = (len_i > c_max_len) ? c_max_len : len_i;
    // r_rcnt holds the index of the next read, so equality means the last read is on the bus now
    assign w_last_read   = (r_rcnt == r_len);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_rcnt  <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_re    <= 1'b0;
            r_raddr <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_src  <= src_i;
                        r_dst  <= dst_i;
                        r_len  <= w_len_clamped;
                        r_wcnt <= '0;
                        if (w_len_clamped == '0) begin
                            r_rcnt  <= '0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_rcnt  <= (AW+1)'(1);
                            r_busy  <= 1'b1;
                            r_re    <= ~w_fill_req;
                            r_raddr <= w_fill_req ? '0 : src_i;
                            r_state <= COPY;
                        end
                    end
                end
                COPY: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_dst + r_wcnt;
                    r_wdata <= w_wr_data;
                    r_wcnt  <= r_wcnt + 1'b1;
                    if (w_last_read) begin
                        r_re    <= 1'b0;
                        r_raddr <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_re    <= ~w_fill;
                        r_raddr <= w_fill ? '0 : r_src + r_rcnt[AW-1:0];
                        r_rcnt  <= r_rcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    r_we    <= 1'b0;
                    r_waddr <= '0;
                    r_wdata <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign mem_re_o    = r_re;
    assign mem_raddr_o = r_raddr;
    assign mem_we_o    = r_we;
    assign mem_waddr_o = r_waddr;
    assign mem_wdata_o = r_wdata;

endmodule

`default_nettype wire
